// File: rtl/uart_receiver_core.sv
// uart_receiver_core: oversampling 8N1 UART receiver (LSB first, idle-high line).
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1 and adds
// a parity_error output; the default build has no parity stage.
//
// Output handshake: valid is a one-clock qualifier for d with no ready; the
// receiver cannot be stalled, so a consumer must capture d when valid is high.
// framing_error (and parity_error when built) are one-clock event pulses that
// never coincide with valid.
module uart_receiver_core #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] d,
    output logic                 valid,
    output logic                 framing_error,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } state_t;

    state_t                state, state_n;
    logic                  rx_meta, rxs;
    logic [CW-1:0]         tick_cnt, tick_n;
    logic [BW-1:0]         bit_cnt, bit_n;
    logic [DATA_BITS-1:0]  shift, shift_n;
    logic                  valid_n, ferr_n;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit, par_n;
    logic                  perr_n;
`endif

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            d             <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            tick_cnt      <= tick_n;
            bit_cnt       <= bit_n;
            shift         <= shift_n;
            valid         <= valid_n;
            framing_error <= ferr_n;
            if (valid_n) begin
                d <= shift;
            end
`ifdef UART_RX_PARITY_EN
            par_bit       <= par_n;
            parity_error  <= perr_n;
`endif
        end
    end

    // Next-state logic; everything advances only on sample_tick, so a
    // permanently low tick freezes the receiver where it is.
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_bit;
        perr_n  = 1'b0;
`endif
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_n = START;
                        tick_n  = '0;
                    end
                end
                START: begin
                    // Mid start bit: a high line here means the edge was a glitch.
                    if (tick_cnt == HALF_M1) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = rxs ? IDLE : DATA;
                    end else begin
                        tick_n = tick_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_n  = '0;
                        shift_n = {rxs, shift[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_n = '0;
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bit_n = bit_cnt + BW'(1);
                        end
                    end else begin
                        tick_n = tick_cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_n  = '0;
                        par_n   = rxs;
                        state_n = STOP;
                    end else begin
                        tick_n = tick_cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_n = '0;
                        if (!rxs) begin
                            // Framing error wins over any parity problem.
                            ferr_n  = 1'b1;
                            state_n = BRK;
                        end else begin
                            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                            if (^{shift, par_bit}) begin
                                perr_n = 1'b1;
                            end else begin
                                valid_n = 1'b1;
                            end
`else
                            valid_n = 1'b1;
`endif
                        end
                    end else begin
                        tick_n = tick_cnt + CW'(1);
                    end
                end
                BRK: begin
                    // Hold off until the line is released so a stuck-low
                    // line reports one error rather than a stream of frames.
                    if (rxs) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver_core.sv
// Self-checking bench for uart_receiver_core (OVERSAMPLE=16, DATA_BITS=8).
// Honours UART_RX_PARITY_EN the same way the design does.
module tb_uart_receiver_core;

  localparam int OS = 16;

  logic       clk;
  logic       rst_n;
  logic       sample_tick;
  logic       rx;
  logic [7:0] d;
  logic       valid;
  logic       framing_error;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif
  logic       busy;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int perr_cnt  = 0;

  int tick_div   = 1;
  int tick_phase = 0;
  bit tick_en    = 1'b1;

  uart_receiver_core #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_tick   (sample_tick),
    .rx            (rx),
    .d             (d),
    .valid         (valid),
    .framing_error (framing_error),
`ifdef UART_RX_PARITY_EN
    .parity_error  (parity_error),
`endif
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset / tick ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (!tick_en) begin
        sample_tick = 1'b0;
      end else begin
        tick_phase  = (tick_phase + 1) % tick_div;
        sample_tick = (tick_phase == 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want completion)");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Scoreboard: every valid pops one expected byte; events are counted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          check("rx_byte", {24'd0, d}, {24'd0, exp_q.pop_front()});
        end
      end
      if (framing_error) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_error) perr_cnt++;
      if (parity_error && (valid || framing_error)) check("perr_exclusive", 32'd1, 32'd0);
`endif
      if (valid && framing_error) check("valid_ferr_exclusive", 32'd1, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    int k = 0;
    int guard = 0;
    int limit = n * tick_div * 2 + 50;
    while (k < n && guard < limit) begin
      @(posedge clk);
      guard++;
      if (sample_tick) k++;
    end
    if (k < n) check("tick_timeout", 32'd1, 32'd0);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    wait_ticks(OS);
  endtask

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  task automatic wait_idle(input int max_cycles);
    int c = 0;
    @(negedge clk);
    while (busy && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int v0, f0, p0;

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_d", {24'd0, d}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_ferr", {31'd0, framing_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_state", {29'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single clean frame, tick held high.
    v0 = valid_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, even_par(8'hA5), 1'b1);
    send_bit(1'b1);
    wait_idle(200);
    check("a5_valid_count", valid_cnt - v0, 32'd1);
    check("a5_ferr_count", ferr_cnt - f0, 32'd0);
    check("a5_busy_after", {31'd0, busy}, 32'd0);
    check("a5_d_held", {24'd0, d}, 32'hA5);

    // Start-bit glitch of 4 ticks.
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(3 * OS);
    check("glitch_valid_count", valid_cnt - v0, 32'd0);
    check("glitch_ferr_count", ferr_cnt - f0, 32'd0);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_d_held", {24'd0, d}, 32'hA5);

    // Bad stop bit followed by a long break.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, even_par(8'h3C), 1'b0);
    wait_ticks(40 * OS);
    check("break_busy_held", {31'd0, busy}, 32'd1);
    check("break_single_ferr", ferr_cnt - f0, 32'd1);
    rx = 1'b1;
    wait_ticks(4);
    wait_idle(200);
    check("break_busy_released", {31'd0, busy}, 32'd0);
    check("break_ferr_total", ferr_cnt - f0, 32'd1);
    check("break_no_valid", valid_cnt - v0, 32'd0);
    check("break_d_held", {24'd0, d}, 32'hA5);
    send_bit(1'b1);

    // Tick held low mid-frame: receiver must freeze, then complete.
    v0 = valid_cnt;
    exp_q.push_back(8'h5A);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(logic'((8'h5A >> i) & 8'h01));
    tick_en = 1'b0;
    repeat (100) @(negedge clk);
    check("freeze_busy", {31'd0, busy}, 32'd1);
    check("freeze_no_valid", valid_cnt - v0, 32'd0);
    tick_en = 1'b1;
    for (int i = 4; i < 8; i++) send_bit(logic'((8'h5A >> i) & 8'h01));
`ifdef UART_RX_PARITY_EN
    send_bit(even_par(8'h5A));
`endif
    send_bit(1'b1);
    send_bit(1'b1);
    check("freeze_valid_count", valid_cnt - v0, 32'd1);

    // Back-to-back frames, no idle gap, tick 1 clk in 4.
    tick_div = 4;
    v0 = valid_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, even_par(8'h00), 1'b1);
    send_frame(8'hFF, even_par(8'hFF), 1'b1);
    send_bit(1'b1);
    wait_idle(400);
    check("b2b_valid_count", valid_cnt - v0, 32'd2);
    check("b2b_ferr_count", ferr_cnt - f0, 32'd0);
    check("b2b_last_d", {24'd0, d}, 32'hFF);
    tick_div = 1;

    // Reset during data bit 3 of 0x81, then a clean 0x42.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(logic'((8'h81 >> i) & 8'h01));
    rx = 1'b0;
    wait_ticks(OS / 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_d", {24'd0, d}, 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(3 * OS);
    check("midreset_no_valid", valid_cnt - v0, 32'd0);
    check("midreset_no_ferr", ferr_cnt - f0, 32'd0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, even_par(8'h42), 1'b1);
    send_bit(1'b1);
    check("after_reset_valid", valid_cnt - v0, 32'd1);
    check("after_reset_d", {24'd0, d}, 32'h42);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1.
    v0 = valid_cnt; p0 = perr_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    check("par_good_valid", valid_cnt - v0, 32'd1);
    check("par_good_perr", perr_cnt - p0, 32'd0);
    v0 = valid_cnt;
    send_frame(8'h07, 1'b0, 1'b1);
    send_bit(1'b1);
    check("par_bad_perr", perr_cnt - p0, 32'd1);
    check("par_bad_no_valid", valid_cnt - v0, 32'd0);
    check("par_bad_d_held", {24'd0, d}, 32'h07);
`else
    p0 = perr_cnt;
    check("no_parity_events", perr_cnt - p0, 32'd0);
`endif

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
